// File: rtl/grid_adventure_game.sv
// grid_adventure_game: grid-based adventure FSM. Player moves on a
// GRID_W x GRID_H room grid using n/s/e/w. The sword must be picked up,
// the dragon slain, then the exit reached. Lives are lost by entering the
// dragon room unarmed.
// Ports: clk, reset (async active-low), n/s/e/w move requests;
//        x_pos/y_pos position, sword, dragon_alive, lives_left status,
//        d (lost, sticky), win (won, sticky).
// Optional: `define GAME_MOVE_LIMIT_EN adds parameter MAX_MOVES and an
//        8-bit moves output. Reaching MAX_MOVES without winning loses.
module grid_adventure_game #(
    parameter int GRID_W   = 4,
    parameter int GRID_H   = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int SWORD_X  = 3,
    parameter int SWORD_Y  = 0,
    parameter int DRAGON_X = 3,
    parameter int DRAGON_Y = 3,
    parameter int EXIT_X   = 0,
    parameter int EXIT_Y   = 3,
    parameter int LIVES    = 2
`ifdef GAME_MOVE_LIMIT_EN
    ,
    parameter int MAX_MOVES = 32
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        n,
    input  logic                        s,
    input  logic                        e,
    input  logic                        w,
    output logic [$clog2(GRID_W)-1:0]   x_pos,
    output logic [$clog2(GRID_H)-1:0]   y_pos,
    output logic                        sword,
    output logic                        dragon_alive,
    output logic [2:0]                  lives_left,
    output logic                        d,
    output logic                        win
`ifdef GAME_MOVE_LIMIT_EN
    ,
    output logic [7:0]                  moves
`endif
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
    localparam logic [XW-1:0] SX0  = XW'(START_X);
    localparam logic [YW-1:0] SY0  = YW'(START_Y);
    localparam logic [XW-1:0] SWX  = XW'(SWORD_X);
    localparam logic [YW-1:0] SWY  = YW'(SWORD_Y);
    localparam logic [XW-1:0] DRX  = XW'(DRAGON_X);
    localparam logic [YW-1:0] DRY  = YW'(DRAGON_Y);
    localparam logic [XW-1:0] EXX  = XW'(EXIT_X);
    localparam logic [YW-1:0] EXY  = YW'(EXIT_Y);
    localparam logic [2:0]    LIV  = 3'(LIVES);

    // Special rooms must be inside the grid and pairwise distinct.
    if (GRID_W < 2 || GRID_W > 16 || GRID_H < 2 || GRID_H > 16 ||
        LIVES < 1 || LIVES > 7 ||
        START_X >= GRID_W || SWORD_X >= GRID_W ||
        DRAGON_X >= GRID_W || EXIT_X >= GRID_W ||
        START_Y >= GRID_H || SWORD_Y >= GRID_H ||
        DRAGON_Y >= GRID_H || EXIT_Y >= GRID_H ||
        (START_X == SWORD_X && START_Y == SWORD_Y) ||
        (START_X == DRAGON_X && START_Y == DRAGON_Y) ||
        (START_X == EXIT_X && START_Y == EXIT_Y) ||
        (SWORD_X == DRAGON_X && SWORD_Y == DRAGON_Y) ||
        (SWORD_X == EXIT_X && SWORD_Y == EXIT_Y) ||
        (DRAGON_X == EXIT_X && DRAGON_Y == EXIT_Y)) begin : g_bad_cfg
        $error("grid_adventure_game: illegal parameter set");
    end

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        DEAD = 2'd1,
        WON  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, nx;
    logic [YW-1:0]   y_q, y_d, ny;
    logic            sword_q, sword_d;
    logic            alive_q, alive_d;
    logic [2:0]      lives_q, lives_d;
    logic            d_q, d_d;
    logic            win_q, win_d;
    logic            valid;
    logic            moved;
`ifdef GAME_MOVE_LIMIT_EN
    logic [7:0]      moves_q, moves_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PLAY;
            x_q     <= SX0;
            y_q     <= SY0;
            sword_q <= 1'b0;
            alive_q <= 1'b1;
            lives_q <= LIV;
            d_q     <= 1'b0;
            win_q   <= 1'b0;
`ifdef GAME_MOVE_LIMIT_EN
            moves_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sword_q <= sword_d;
            alive_q <= alive_d;
            lives_q <= lives_d;
            d_q     <= d_d;
            win_q   <= win_d;
`ifdef GAME_MOVE_LIMIT_EN
            moves_q <= moves_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sword_d = sword_q;
        alive_d = alive_q;
        lives_d = lives_q;
        d_d     = d_q;
        win_d   = win_q;
        nx      = x_q;
        ny      = y_q;
`ifdef GAME_MOVE_LIMIT_EN
        moves_d = moves_q;
`endif
        valid = (state_q == PLAY) && $onehot({n, s, e, w});
        if (valid) begin
            // Edge moves clamp: destination stays the current room.
            unique case (1'b1)
                n: if (y_q != YMAX) ny = y_q + 1'b1;
                s: if (y_q != '0)   ny = y_q - 1'b1;
                e: if (x_q != XMAX) nx = x_q + 1'b1;
                w: if (x_q != '0)   nx = x_q - 1'b1;
            endcase
        end
        moved = (nx != x_q) || (ny != y_q);
        if (valid) begin
            x_d = nx;
            y_d = ny;
        end
        // Room events fire only on a real change of room.
        if (valid && moved) begin
            if (nx == SWX && ny == SWY)
                sword_d = 1'b1;
            if (nx == DRX && ny == DRY) begin
                if (sword_q) begin
                    alive_d = 1'b0;
                end else if (alive_q) begin
                    if (lives_q == 3'd1) begin
                        lives_d = 3'd0;
                        d_d     = 1'b1;
                        state_d = DEAD;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        x_d     = SX0;
                        y_d     = SY0;
                    end
                end
            end
            if (nx == EXX && ny == EXY && !alive_q) begin
                win_d   = 1'b1;
                state_d = WON;
            end
        end
`ifdef GAME_MOVE_LIMIT_EN
        if (valid && moves_q != 8'hFF) begin
            moves_d = moves_q + 8'd1;
            if (32'(moves_d) == MAX_MOVES && !win_d) begin
                d_d     = 1'b1;
                state_d = DEAD;
            end
        end
`endif
    end

    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign sword        = sword_q;
    assign dragon_alive = alive_q;
    assign lives_left   = lives_q;
    assign d            = d_q;
    assign win          = win_q;
`ifdef GAME_MOVE_LIMIT_EN
    assign moves        = moves_q;
`endif

endmodule
